// File: rtl/dual_issue_stage.sv
// Issue stage: buffers one fetched instruction pair and dual-issues it to the
// even/odd pipes when classes and register dependences allow, else splits it.
module dual_issue_stage #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_instr0,
  input  logic [31:0]      fetch_instr1,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_pipe0,
  input  logic             fetch_pipe1,
  input  logic             fetch_wr0,
  input  logic             issue_stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  pc_wb,
  output logic [31:0]      instr_even,
  output logic [31:0]      instr_odd,
  output logic [PC_W-1:0]  pc,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] dual_count
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_PAIR   = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  logic [1:0]      state;
  logic [31:0]     slot0;
  logic [31:0]     slot1;
  logic            slot0_pipe;
  logic            slot1_pipe;
  logic            pair_dep;
  logic [PC_W-1:0] pair_pc;

  logic [6:0] rt0;
  logic [6:0] ra1;
  logic [6:0] rb1;
  logic       fetch_dep;
  logic       go;
  logic       dual_now;
  logic       accept;

  // Fields are numbered MSB-first in the ISA: rt=[25:31] is bits [6:0] here,
  // ra=[18:24] is [13:7], rb=[11:17] is [20:14].
  always_comb begin
    rt0       = fetch_instr0[6:0];
    ra1       = fetch_instr1[13:7];
    rb1       = fetch_instr1[20:14];
    fetch_dep = fetch_wr0 & ((rt0 == ra1) | (rt0 == rb1));
  end

  always_comb begin
    go          = ~issue_stall & ~branch_taken;
    dual_now    = (state == ST_PAIR) & ~slot0_pipe & slot1_pipe & ~pair_dep;
    fetch_ready = go & ((state == ST_EMPTY) | (state == ST_SECOND) | dual_now);
    accept      = fetch_valid & fetch_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_EMPTY;
      slot0          <= '0;
      slot1          <= '0;
      slot0_pipe     <= 1'b0;
      slot1_pipe     <= 1'b0;
      pair_dep       <= 1'b0;
      pair_pc        <= '0;
      instr_even     <= '0;
      instr_odd      <= '0;
      pc             <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      dual_count     <= '0;
    end else begin
      redirect_valid <= branch_taken;
      if (branch_taken) begin
        redirect_pc <= pc_wb;
        state       <= ST_EMPTY;
        instr_even  <= '0;
        instr_odd   <= '0;
      end else if (!issue_stall) begin
        case (state)
          ST_PAIR: begin
            pc <= pair_pc;
            if (dual_now) begin
              instr_even <= slot0;
              instr_odd  <= slot1;
              state      <= ST_EMPTY;
              if (dual_count != '1) dual_count <= dual_count + CNT_W'(1);
            end else begin
              instr_even <= slot0_pipe ? '0 : slot0;
              instr_odd  <= slot0_pipe ? slot0 : '0;
              state      <= ST_SECOND;
            end
          end
          ST_SECOND: begin
            instr_even <= slot1_pipe ? '0 : slot1;
            instr_odd  <= slot1_pipe ? slot1 : '0;
            pc         <= pair_pc + PC_W'(1);
            state      <= ST_EMPTY;
          end
          default: begin
            instr_even <= '0;
            instr_odd  <= '0;
            state      <= ST_EMPTY;
          end
        endcase
        // A newly accepted pair overrides the drain transition above; the
        // outgoing slot values were already sampled from the old registers.
        if (accept) begin
          slot0      <= fetch_instr0;
          slot1      <= fetch_instr1;
          slot0_pipe <= fetch_pipe0;
          slot1_pipe <= fetch_pipe1;
          pair_dep   <= fetch_dep;
          pair_pc    <= fetch_pc;
          state      <= ST_PAIR;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_stage.sv
// Bench for dual_issue_stage: directed vector table, a reset-mid-stall sequence,
// then random traffic against a queue-based reference model.
module tb_dual_issue_stage;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  localparam logic [31:0] T1A = 32'h58808083;
  localparam logic [31:0] T1B = 32'h3B614206;
  localparam logic [31:0] T2A = 32'h0BE0C187;
  localparam logic [31:0] T2B = 32'h3B614386;
  localparam logic [31:0] T3B = 32'h1900C388;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [31:0]      fetch_instr0;
  logic [31:0]      fetch_instr1;
  logic [PC_W-1:0]  fetch_pc;
  logic             fetch_pipe0;
  logic             fetch_pipe1;
  logic             fetch_wr0;
  logic             issue_stall;
  logic             branch_taken;
  logic [PC_W-1:0]  pc_wb;
  logic [31:0]      instr_even;
  logic [31:0]      instr_odd;
  logic [PC_W-1:0]  pc;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] dual_count;

  dual_issue_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1), .fetch_pc(fetch_pc),
    .fetch_pipe0(fetch_pipe0), .fetch_pipe1(fetch_pipe1), .fetch_wr0(fetch_wr0),
    .issue_stall(issue_stall), .branch_taken(branch_taken), .pc_wb(pc_wb),
    .instr_even(instr_even), .instr_odd(instr_odd), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dual_count(dual_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] i0, i1;
    logic [7:0]  fpc;
    logic        p0, p1, wr0, st, br;
    logic [7:0]  pcwb;
    logic        e_rdy;
    logic [31:0] e_even, e_odd;
    logic [7:0]  e_pc;
    logic        e_rv;
    logic [7:0]  e_rpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [7:0] fpc, input logic p0, input logic p1, input logic wr0,
                     input logic st, input logic br, input logic [7:0] pcwb,
                     input logic e_rdy, input logic [31:0] e_even, input logic [31:0] e_odd,
                     input logic [7:0] e_pc, input logic e_rv, input logic [7:0] e_rpc,
                     input logic [31:0] e_cnt);
    vec_t t;
    t.v = v; t.i0 = i0; t.i1 = i1; t.fpc = fpc; t.p0 = p0; t.p1 = p1; t.wr0 = wr0;
    t.st = st; t.br = br; t.pcwb = pcwb; t.e_rdy = e_rdy; t.e_even = e_even;
    t.e_odd = e_odd; t.e_pc = e_pc; t.e_rv = e_rv; t.e_rpc = e_rpc; t.e_cnt = e_cnt;
    tbl.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    fetch_valid = t.v; fetch_instr0 = t.i0; fetch_instr1 = t.i1; fetch_pc = t.fpc;
    fetch_pipe0 = t.p0; fetch_pipe1 = t.p1; fetch_wr0 = t.wr0;
    issue_stall = t.st; branch_taken = t.br; pc_wb = t.pcwb;
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    chk({tag, " even"}, instr_even, t.e_even);
    chk({tag, " odd"}, instr_odd, t.e_odd);
    chk({tag, " pc"}, 32'(pc), 32'(t.e_pc));
    chk({tag, " rv"}, 32'(redirect_valid), 32'(t.e_rv));
    chk({tag, " rpc"}, 32'(redirect_pc), 32'(t.e_rpc));
    chk({tag, " cnt"}, 32'(dual_count), t.e_cnt);
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    drive(t);
    #1 chk({tag, " ready"}, 32'(fetch_ready), 32'(t.e_rdy));
    @(posedge clk);
    #1 check_outs(tag, t);
  endtask

  // Reference model: pending instructions held as a queue, oldest first.
  typedef struct { logic [31:0] instr; logic pipe; logic [7:0] pc; } ent_t;
  ent_t        mq[$];
  logic        mdep;
  logic [31:0] m_even, m_odd, m_cnt;
  logic [7:0]  m_pc, m_rpc;
  logic        m_rv;

  function automatic logic m_dual();
    return (mq.size() == 2) && !mq[0].pipe && mq[1].pipe && !mdep;
  endfunction

  function automatic logic m_ready();
    return !issue_stall && !branch_taken && (mq.size() != 2 || m_dual());
  endfunction

  task automatic m_reset();
    mq.delete(); mdep = 0;
    m_even = 0; m_odd = 0; m_cnt = 0; m_pc = 0; m_rpc = 0; m_rv = 0;
  endtask

  task automatic m_edge(input logic rdy);
    ent_t e;
    m_rv = branch_taken;
    if (branch_taken) begin
      mq.delete(); m_even = 0; m_odd = 0; m_rpc = pc_wb;
    end else if (!issue_stall) begin
      if (m_dual()) begin
        m_even = mq[0].instr; m_odd = mq[1].instr; m_pc = mq[0].pc;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        mq.delete();
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_even = e.pipe ? 32'h0 : e.instr;
        m_odd  = e.pipe ? e.instr : 32'h0;
        m_pc   = e.pc;
      end else begin
        m_even = 0; m_odd = 0;
      end
      if (rdy && fetch_valid) begin
        mq.push_back('{instr: fetch_instr0, pipe: fetch_pipe0, pc: fetch_pc});
        mq.push_back('{instr: fetch_instr1, pipe: fetch_pipe1, pc: fetch_pc + 8'd1});
        mdep = fetch_wr0 && (fetch_instr0[6:0] == fetch_instr1[13:7] ||
                             fetch_instr0[6:0] == fetch_instr1[20:14]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    vec_t t;
    logic [31:0] r0, r1;
    logic        rdy;

    z = '{v: 0, i0: 0, i1: 0, fpc: 0, p0: 0, p1: 0, wr0: 0, st: 0, br: 0, pcwb: 0,
          e_rdy: 0, e_even: 0, e_odd: 0, e_pc: 0, e_rv: 0, e_rpc: 0, e_cnt: 0};
    drive(z);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outs("reset", z);
    reset = 1'b0;

    //  v  i0   i1   fpc    p0 p1 wr st br pcwb | rdy even odd  pc    rv rpc  cnt
    add(1, T1A, T1B, 8'h10, 0, 1, 1, 0, 0, 8'h0,  1, 0,   0,   8'h00, 0, 8'h0,  0);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  1, T1A, T1B, 8'h10, 0, 8'h0,  1);
    add(1, T2A, T2B, 8'h20, 0, 1, 1, 0, 0, 8'h0,  1, 0,   0,   8'h10, 0, 8'h0,  1);
    add(1, T1A, T1B, 8'h30, 0, 1, 1, 0, 0, 8'h0,  0, T2A, 0,   8'h20, 0, 8'h0,  1);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  1, 0,   T2B, 8'h21, 0, 8'h0,  1);
    add(1, T1A, T3B, 8'hFF, 0, 0, 0, 0, 0, 8'h0,  1, 0,   0,   8'h21, 0, 8'h0,  1);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  0, T1A, 0,   8'hFF, 0, 8'h0,  1);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  1, T3B, 0,   8'h00, 0, 8'h0,  1);
    add(1, T1A, T1B, 8'h40, 0, 1, 1, 0, 0, 8'h0,  1, 0,   0,   8'h00, 0, 8'h0,  1);
    add(1, T1A, T1B, 8'h42, 0, 1, 1, 0, 0, 8'h0,  1, T1A, T1B, 8'h40, 0, 8'h0,  2);
    add(1, T1A, T1B, 8'h44, 0, 1, 1, 0, 0, 8'h0,  1, T1A, T1B, 8'h42, 0, 8'h0,  3);
    add(1, T1A, T1B, 8'h46, 0, 1, 1, 0, 0, 8'h0,  1, T1A, T1B, 8'h44, 0, 8'h0,  4);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  1, T1A, T1B, 8'h46, 0, 8'h0,  5);
    add(1, T2A, T2B, 8'h50, 0, 1, 1, 0, 0, 8'h0,  1, 0,   0,   8'h46, 0, 8'h0,  5);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  0, T2A, 0,   8'h50, 0, 8'h0,  5);
    add(1, T1A, T1B, 8'h60, 0, 1, 1, 0, 1, 8'h40, 0, 0,   0,   8'h50, 1, 8'h40, 5);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  1, 0,   0,   8'h50, 0, 8'h40, 5);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  1, 0,   0,   8'h50, 0, 8'h40, 5);
    add(1, T2A, T2B, 8'h70, 0, 1, 1, 0, 0, 8'h0,  1, 0,   0,   8'h50, 0, 8'h40, 5);
    add(0, 0,   0,   8'h00, 0, 0, 0, 0, 0, 8'h0,  0, T2A, 0,   8'h70, 0, 8'h40, 5);
    add(1, T1A, T1B, 8'h80, 0, 1, 1, 0, 0, 8'h0,  1, 0,   T2B, 8'h71, 0, 8'h40, 5);
    add(1, T1A, T1B, 8'h90, 0, 1, 1, 1, 0, 8'h0,  0, 0,   T2B, 8'h71, 0, 8'h40, 5);
    add(1, T1A, T1B, 8'h90, 0, 1, 1, 1, 0, 8'h0,  0, 0,   T2B, 8'h71, 0, 8'h40, 5);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Third stall cycle: asynchronous reset lands between clock edges.
    t = tbl[tbl.size()-1];
    drive(t);
    #1 chk("stall3 ready", 32'(fetch_ready), 32'h0);
    #2 reset = 1'b1;
    #1 check_outs("async_reset", z);
    @(posedge clk);
    #1 reset = 1'b0;
    t = z;
    t.e_rdy = 1;
    run_vec(t, "post_reset");

    // Random traffic against the reference model.
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      r0 = $urandom;
      r1 = $urandom;
      if ($urandom_range(0, 3) == 0) r1[13:7] = r0[6:0];
      else if ($urandom_range(0, 3) == 0) r1[20:14] = r0[6:0];
      fetch_instr0 = r0;
      fetch_instr1 = r1;
      fetch_valid  = ($urandom_range(0, 9) < 7);
      fetch_pc     = 8'($urandom);
      fetch_pipe0  = ($urandom_range(0, 3) == 0);
      fetch_pipe1  = ($urandom_range(0, 3) != 0);
      fetch_wr0    = $urandom_range(0, 1) == 1;
      issue_stall  = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      pc_wb        = 8'($urandom);
      rdy = m_ready();
      #1 chk("rnd ready", 32'(fetch_ready), 32'(rdy));
      @(posedge clk);
      m_edge(rdy);
      #1;
      chk("rnd even", instr_even, m_even);
      chk("rnd odd", instr_odd, m_odd);
      chk("rnd pc", 32'(pc), 32'(m_pc));
      chk("rnd rv", 32'(redirect_valid), 32'(m_rv));
      if (m_rv) chk("rnd rpc", 32'(redirect_pc), 32'(m_rpc));
      chk("rnd cnt", 32'(dual_count), m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
